// File: rtl/lcd_pkg.sv
// Shared constants, state/opcode enums and DDRAM address helpers for the
// HD44780-style LCD bus responder.
package lcd_pkg;

  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam int         LINE_LEN    = 40;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [6:0] LINE0_LAST  = LINE0_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE1_LAST  = LINE1_BASE + 7'(LINE_LEN - 1);

  localparam logic [7:0] CMD_CLEAR_MASK   = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK    = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL_MASK = 8'h08;
  localparam logic [7:0] CMD_SHIFT_MASK   = 8'h10;
  localparam logic [7:0] CMD_FUNC_MASK    = 8'h20;
  localparam logic [7:0] CMD_CGRAM_MASK   = 8'h40;
  localparam logic [7:0] CMD_DDRAM_MASK   = 8'h80;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR_FILL} lcdState_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPCTL,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } lcdOp_t;

  // The instruction is selected by the highest set bit of the data byte.
  function automatic lcdOp_t decodeOp(input logic [7:0] db);
    if ((db & CMD_DDRAM_MASK) != 8'h00)        return OP_DDRAM;
    else if ((db & CMD_CGRAM_MASK) != 8'h00)   return OP_CGRAM;
    else if ((db & CMD_FUNC_MASK) != 8'h00)    return OP_FUNC;
    else if ((db & CMD_SHIFT_MASK) != 8'h00)   return OP_SHIFT;
    else if ((db & CMD_DISPCTL_MASK) != 8'h00) return OP_DISPCTL;
    else if ((db & CMD_ENTRY_MASK) != 8'h00)   return OP_ENTRY;
    else if ((db & CMD_HOME_MASK) != 8'h00)    return OP_HOME;
    else if ((db & CMD_CLEAR_MASK) != 8'h00)   return OP_CLEAR;
    else                                       return OP_NONE;
  endfunction

  function automatic logic lineOffsetValid(input logic [5:0] col);
    return col < 6'(LINE_LEN);
  endfunction

  function automatic logic [6:0] addrToIndex(input logic [6:0] addr);
    if (addr[6]) return 7'(LINE_LEN) + {1'b0, addr[5:0]};
    else         return {1'b0, addr[5:0]};
  endfunction

  // Address counter step with the line-to-line wrap of a 2x40 display.
  function automatic logic [6:0] acStep(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE0_LAST) return LINE1_BASE;
      if (ac == LINE1_LAST) return LINE0_BASE;
      return ac + 7'd1;
    end else begin
      if (ac == LINE0_BASE) return LINE1_LAST;
      if (ac == LINE1_BASE) return LINE0_LAST;
      return ac - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// Parallel LCD bus: driver-side master, display-side slave.
interface lcd_bus_responder_if;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;

  modport master (output rs, rw, en, db_in, input db_out, db_oe);
  modport slave  (input rs, rw, en, db_in, output db_out, db_oe);
endinterface

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: port A for bus access and clear fill, port B a
// registered scan read that returns a space for unmapped addresses.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_aWe,
  input  logic [6:0] i_aIdx,
  input  logic [7:0] i_aWdata,
  output logic [7:0] o_aRdata,
  input  logic       i_bValid,
  input  logic [6:0] i_bIdx,
  output logic [7:0] o_bRdata
);

  logic [7:0] r_mem [DDRAM_DEPTH];
  logic [7:0] r_aRdata;
  logic [7:0] r_bRdata;

  always_ff @(posedge clk) begin
    if (i_aWe) r_mem[i_aIdx] <= i_aWdata;
    r_aRdata <= r_mem[i_aIdx];
  end

  // Scan read sees the pre-write value when it hits the cell being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_bRdata <= SPACE_CHAR;
    else if (i_bValid) r_bRdata <= r_mem[i_bIdx];
    else               r_bRdata <= SPACE_CHAR;
  end

  assign o_aRdata = r_aRdata;
  assign o_bRdata = r_bRdata;

endmodule

// File: rtl/lcd_bus_responder.sv
// Target-side HD44780-style bus model: samples transfers on the falling edge
// of en, executes the command subset, tracks busy and serves bus/scan reads.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 80000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_bus_responder_if.slave bus,
  output logic               busy,
  output logic               disp_on,
  output logic               cursor_on,
  output logic               blink_on,
  input  logic [6:0]         rd_addr,
  output logic [7:0]         rd_data,
  output logic               err
);

  lcdState_t  r_state, w_nextState;
  logic       r_en1, r_en2, r_en3, r_rs1, r_rs2, r_rs3, r_rw1, r_rw2, r_rw3;
  logic [7:0] r_db1, r_db2, r_db3;
  logic       r_cmdRs, r_cmdRw, r_cmdAccept, r_pend, r_err, r_initDone;
  logic [7:0] r_cmdDb;
  logic [31:0] r_busyCnt;
  logic [6:0] r_ac, r_fillIdx;
  logic       r_id, r_s, r_d, r_c, r_b, r_dl, r_n, r_f;
  logic       w_fall, w_accept, w_addrReject, w_isClear, w_dbOe, w_ramWe, w_unused;
  logic [6:0] w_ramIdx;
  logic [7:0] w_ramWdata, w_ramRdata;
  lcdOp_t     w_fallOp, w_op;

  // The third stage holds the last values seen while en was still high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_en1, r_en2, r_en3} <= '0;
      {r_rs1, r_rs2, r_rs3} <= '0;
      {r_rw1, r_rw2, r_rw3} <= '0;
      r_db1 <= '0;
      r_db2 <= '0;
      r_db3 <= '0;
    end else begin
      {r_en1, r_en2, r_en3} <= {bus.en, r_en1, r_en2};
      {r_rs1, r_rs2, r_rs3} <= {bus.rs, r_rs1, r_rs2};
      {r_rw1, r_rw2, r_rw3} <= {bus.rw, r_rw1, r_rw2};
      r_db1 <= bus.db_in;
      r_db2 <= r_db1;
      r_db3 <= r_db2;
    end
  end

  assign w_fall       = r_en3 & ~r_en2;
  assign w_fallOp     = decodeOp(r_db3);
  assign w_addrReject = ~r_rs3 & (w_fallOp == OP_DDRAM) & ~lineOffsetValid(r_db3[5:0]);
  assign w_accept     = r_rw3 | (~busy & ~w_addrReject);
  assign w_isClear    = ~r_rs3 & (w_fallOp == OP_CLEAR);
  assign busy         = (r_busyCnt != 32'd0) | (r_state == CLEAR_FILL);

  // Acceptance and busy loading are decided the cycle the edge is detected;
  // a transfer seen mid-fill is parked until the fill finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmdRs     <= 1'b0;
      r_cmdRw     <= 1'b0;
      r_cmdDb     <= '0;
      r_cmdAccept <= 1'b0;
      r_pend      <= 1'b0;
      r_err       <= 1'b0;
      r_busyCnt   <= '0;
    end else begin
      r_err <= w_fall & ~w_accept;
      if (w_fall) begin
        r_cmdRs     <= r_rs3;
        r_cmdRw     <= r_rw3;
        r_cmdDb     <= r_db3;
        r_cmdAccept <= w_accept;
      end
      if (w_fall && (r_state != IDLE || !r_initDone)) r_pend <= 1'b1;
      else if (r_state == EXEC)                      r_pend <= 1'b0;
      if (w_fall && w_accept && !r_rw3)
        r_busyCnt <= w_isClear ? CLEAR_CYCLES : BUSY_CYCLES;
      else if (r_busyCnt != 32'd0)
        r_busyCnt <= r_busyCnt - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  assign w_op = decodeOp(r_cmdDb);

  // Next state plus the RAM port A mux shared between bus writes and fill.
  always_comb begin
    w_nextState = r_state;
    w_ramWe     = 1'b0;
    w_ramIdx    = addrToIndex(r_ac);
    w_ramWdata  = r_cmdDb;
    unique case (r_state)
      IDLE: begin
        if (!r_initDone)          w_nextState = CLEAR_FILL;
        else if (w_fall || r_pend) w_nextState = EXEC;
      end
      EXEC: begin
        w_ramWe = r_cmdAccept & ~r_cmdRw & r_cmdRs;
        if (r_cmdAccept && !r_cmdRw && !r_cmdRs && w_op == OP_CLEAR)
          w_nextState = CLEAR_FILL;
        else
          w_nextState = IDLE;
      end
      CLEAR_FILL: begin
        w_ramWe    = 1'b1;
        w_ramIdx   = r_fillIdx;
        w_ramWdata = SPACE_CHAR;
        if (r_fillIdx == 7'(DDRAM_DEPTH - 1)) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac       <= LINE0_BASE;
      {r_id, r_s} <= 2'b10;
      {r_d, r_c, r_b} <= 3'b000;
      {r_dl, r_n, r_f} <= 3'b000;
      r_fillIdx  <= '0;
      r_initDone <= 1'b0;
    end else if (r_state == CLEAR_FILL) begin
      if (r_fillIdx == 7'(DDRAM_DEPTH - 1)) begin
        r_fillIdx  <= '0;
        r_initDone <= 1'b1;
      end else begin
        r_fillIdx <= r_fillIdx + 7'd1;
      end
    end else if (r_state == EXEC && r_cmdAccept) begin
      if (r_cmdRs) begin
        r_ac <= acStep(r_ac, r_id);
      end else if (!r_cmdRw) begin
        unique case (w_op)
          OP_CLEAR:   begin r_ac <= LINE0_BASE; r_id <= 1'b1; end
          OP_HOME:    r_ac <= LINE0_BASE;
          OP_ENTRY:   {r_id, r_s} <= r_cmdDb[1:0];
          OP_DISPCTL: {r_d, r_c, r_b} <= r_cmdDb[2:0];
          OP_SHIFT:   if (!r_cmdDb[3]) r_ac <= acStep(r_ac, r_cmdDb[2]);
          OP_FUNC:    {r_dl, r_n, r_f} <= r_cmdDb[4:2];
          OP_DDRAM:   r_ac <= r_cmdDb[6:0];
          default:    ;
        endcase
      end
    end
  end

  // Entry-shift and function-set bits are held for completeness only.
  assign w_unused = r_s ^ r_dl ^ r_n ^ r_f;

  assign w_dbOe      = r_en2 & r_rw2;
  assign bus.db_oe   = w_dbOe;
  assign bus.db_out  = w_dbOe ? (r_rs2 ? w_ramRdata : {busy, r_ac}) : 8'h00;
  assign disp_on     = r_d;
  assign cursor_on   = r_c;
  assign blink_on    = r_b;
  assign err         = r_err;

  lcd_ddram u_ddram (
    .clk      (clk),
    .rst      (rst),
    .i_aWe    (w_ramWe),
    .i_aIdx   (w_ramIdx),
    .i_aWdata (w_ramWdata),
    .o_aRdata (w_ramRdata),
    .i_bValid (lineOffsetValid(rd_addr[5:0])),
    .i_bIdx   (addrToIndex(rd_addr)),
    .o_bRdata (rd_data)
  );

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: drives bus transfers through the
// interface and compares bus, scan-port and status outputs to fixed values.
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, disp_on, cursor_on, blink_on, err;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  int         testsRun = 0;
  int         testsFailed = 0;
  int         errSeen = 0;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_CYCLES(30), .CLEAR_CYCLES(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) errSeen <= errSeen + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus transfer: en high 5 clk (db_out sampled at the end), then low 6 clk.
  task automatic applyStimulus(input logic rsV, input logic rwV, input logic [7:0] dbV,
                               output logic [7:0] rdV);
    @(negedge clk);
    bus.rs = rsV;
    bus.rw = rwV;
    bus.db_in = dbV;
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    rdV = bus.db_out;
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic writeCmd(input logic [7:0] c);
    logic [7:0] d;
    applyStimulus(1'b0, 1'b0, c, d);
  endtask

  task automatic writeData(input logic [7:0] c);
    logic [7:0] d;
    applyStimulus(1'b1, 1'b0, c, d);
  endtask

  task automatic readStatus(output logic [7:0] v);
    applyStimulus(1'b0, 1'b1, 8'h00, v);
  endtask

  task automatic waitReady(input string tag);
    logic [7:0] v;
    int n = 0;
    do begin
      readStatus(v);
      n++;
    end while (v[7] && n < 40);
    checkOutput(tag, {31'd0, v[7]}, 32'd0);
  endtask

  task automatic scanRead(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] msg [7] = '{8'h4D, 8'h41, 8'h53, 8'h54, 8'h45, 8'h52, 8'h31};
    int errBefore;
    int busyCycles;

    bus.rs = 1'b0;
    bus.rw = 1'b0;
    bus.en = 1'b0;
    bus.db_in = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_db_oe", {31'd0, bus.db_oe}, 32'd0);
    checkOutput("rst_db_out", {24'd0, bus.db_out}, 32'h00);
    checkOutput("rst_disp", {29'd0, disp_on, cursor_on, blink_on}, 32'd0);
    checkOutput("rst_rd_data", {24'd0, rd_data}, 32'h20);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    waitReady("powerup_ready");
    readStatus(v);
    checkOutput("powerup_bf_ac", {24'd0, v}, 32'h00);
    for (int a = 0; a < 128; a++) begin
      if (a[5:0] < 6'd40) begin
        scanRead(7'(a), v);
        checkOutput("powerup_scan", {24'd0, v}, 32'h20);
      end
    end

    writeCmd(8'h38); waitReady("ready_38");
    writeCmd(8'h0E); waitReady("ready_0E");
    writeCmd(8'h06); waitReady("ready_06");
    writeCmd(8'h01); waitReady("ready_clear");
    for (int i = 0; i < 7; i++) begin
      writeData(msg[i]);
      waitReady("ready_msg");
    end
    checkOutput("dispctl", {29'd0, disp_on, cursor_on, blink_on}, 32'b110);
    for (int i = 0; i < 7; i++) begin
      scanRead(7'(i), v);
      checkOutput("msg_scan", {24'd0, v}, {24'd0, msg[i]});
    end
    readStatus(v);
    checkOutput("msg_ac", {24'd0, v}, 32'h07);

    writeCmd(8'hA7); waitReady("ready_A7");
    writeData(8'h41); waitReady("ready_41");
    writeData(8'h42); waitReady("ready_42");
    scanRead(7'h27, v); checkOutput("wrap_scan_27", {24'd0, v}, 32'h41);
    scanRead(7'h40, v); checkOutput("wrap_scan_40", {24'd0, v}, 32'h42);
    scanRead(7'h28, v); checkOutput("scan_invalid", {24'd0, v}, 32'h20);
    readStatus(v);      checkOutput("wrap_ac", {24'd0, v}, 32'h41);

    writeCmd(8'h04); waitReady("ready_04");
    writeCmd(8'h80); waitReady("ready_80");
    writeData(8'h5A); waitReady("ready_5A");
    scanRead(7'h00, v); checkOutput("dec_scan_00", {24'd0, v}, 32'h5A);
    readStatus(v);      checkOutput("dec_wrap_ac", {24'd0, v}, 32'h67);

    errBefore = errSeen;
    writeData(8'h33);
    writeData(8'h44);
    readStatus(v);
    checkOutput("busy_bf_read", {24'd0, v}, 32'hE6);
    waitReady("ready_busywr");
    checkOutput("busy_err_count", 32'(errSeen - errBefore), 32'd1);
    scanRead(7'h67, v); checkOutput("busy_scan_67", {24'd0, v}, 32'h33);
    scanRead(7'h66, v); checkOutput("busy_scan_66", {24'd0, v}, 32'h20);
    readStatus(v);      checkOutput("busy_ac", {24'd0, v}, 32'h66);

    errBefore = errSeen;
    writeCmd(8'hB0);
    repeat (3) @(negedge clk);
    checkOutput("badaddr_err_count", 32'(errSeen - errBefore), 32'd1);
    readStatus(v);
    checkOutput("badaddr_ac", {24'd0, v}, 32'h66);

    writeCmd(8'h06); waitReady("ready_06b");
    writeCmd(8'h85); waitReady("ready_85");
    applyStimulus(1'b1, 1'b1, 8'h00, v);
    checkOutput("data_read", {24'd0, v}, 32'h52);
    readStatus(v);
    checkOutput("data_read_ac", {24'd0, v}, 32'h06);

    // Clear, then reset during the 40th fill cycle.
    @(negedge clk);
    bus.rs = 1'b0;
    bus.rw = 1'b0;
    bus.db_in = 8'h01;
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    repeat (43) @(negedge clk);
    checkOutput("midclear_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_disp", {29'd0, disp_on, cursor_on, blink_on}, 32'd0);
    checkOutput("midrst_rd_data", {24'd0, rd_data}, 32'h20);
    checkOutput("midrst_oe_err", {30'd0, bus.db_oe, err}, 32'd0);
    checkOutput("midrst_db_out", {24'd0, bus.db_out}, 32'h00);
    rst = 1'b0;
    busyCycles = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy) busyCycles++;
    end
    checkOutput("refill_busy_len", 32'(busyCycles), 32'd80);
    scanRead(7'h40, v); checkOutput("refill_scan_40", {24'd0, v}, 32'h20);
    scanRead(7'h67, v); checkOutput("refill_scan_67", {24'd0, v}, 32'h20);
    scanRead(7'h27, v); checkOutput("refill_scan_27", {24'd0, v}, 32'h20);
    readStatus(v);      checkOutput("refill_bf_ac", {24'd0, v}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
